// File: rtl/valid_pipe.sv
// valid_pipe: DELAY-stage valid/data pipe with ready/valid backpressure and bubble collapsing.
// Optional macro VALID_PIPE_DATA_RESET_EN clears data registers on reset/flush.
module valid_pipe #(
    parameter int DELAY = 1,
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(DELAY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    count
);

    if (DELAY < 1) begin : g_bad_delay
        $error("valid_pipe: DELAY must be at least 1");
    end

    logic             vld_p  [DELAY];
    logic [WIDTH-1:0] data_p [DELAY];
    logic [DELAY-1:0] load;
    logic             in_fire;
    logic             out_fire;

    // A stage can load unless it and every stage after it are full with the consumer stalled.
    always_comb begin : advance_chain
        logic tail_full;
        tail_full = 1'b1;
        load      = '0;
        for (int k = DELAY - 1; k >= 0; k--) begin
            tail_full = tail_full & vld_p[k];
            load[k]   = o_ready | ~tail_full;
        end
    end

    assign i_ready  = load[0] & ~flush & ~reset;
    assign in_fire  = i_valid & i_ready;
    assign out_fire = vld_p[DELAY-1] & o_ready;
    assign o_valid  = vld_p[DELAY-1];
    assign o_data   = data_p[DELAY-1];

    for (genvar k = 0; k < DELAY; k++) begin : g_stage
        logic             vld_in;
        logic [WIDTH-1:0] data_in;

        if (k == 0) begin : g_head
            assign vld_in  = in_fire;
            assign data_in = i_data;
        end else begin : g_body
            assign vld_in  = vld_p[k-1];
            assign data_in = data_p[k-1];
        end

        // stage k boundary
        always_ff @(posedge clk) begin
            if (reset || flush) begin
                vld_p[k] <= 1'b0;
            end else if (load[k]) begin
                vld_p[k] <= vld_in;
            end
        end

`ifdef VALID_PIPE_DATA_RESET_EN
        always_ff @(posedge clk) begin
            if (reset || flush) begin
                data_p[k] <= '0;
            end else if (load[k]) begin
                data_p[k] <= data_in;
            end
        end
`else
        always_ff @(posedge clk) begin
            if (load[k]) begin
                data_p[k] <= data_in;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count <= '0;
        end else if (in_fire && !out_fire) begin
            count <= count + CW'(1);
        end else if (!in_fire && out_fire) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_valid_pipe.sv
// Scoreboard bench for valid_pipe (DELAY=3, WIDTH=8): directed vectors plus a random-handshake run.
module tb_valid_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       i_valid;
    logic       i_ready;
    logic [7:0] i_data;
    logic       o_valid;
    logic       o_ready;
    logic [7:0] o_data;
    logic [1:0] count;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic [7:0] sb_q [$];

    valid_pipe #(.DELAY(3), .WIDTH(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
        .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: accepted beats are queued, output transfers pop and compare, flush/reset discard.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count_vs_inflight", int'(count), sb_q.size());
            if (reset) begin
                sb_q.delete();
            end else begin
                if (o_valid && o_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: actual=%0h expected=none", o_data);
                    end else begin
                        chk("sb_data", o_data, sb_q.pop_front());
                    end
                end
                if (flush) sb_q.delete();
                else if (i_valid && i_ready) sb_q.push_back(i_data);
            end
        end
    end

    initial begin
        logic [7:0] cur;
        logic       fire;
        int         sent;
        int         cyc;

        reset = 1'b1; flush = 1'b0; i_valid = 1'b0; i_data = '0; o_ready = 1'b1;
        step();
        step();
        #1 chk("rst_iready_low", i_ready, 0);
        reset = 1'b0;
        mon_en = 1'b1;
        step();
        #1;
        chk("rst_ovalid", o_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_iready", i_ready, 1);

        // back-to-back stream, consumer always ready
        step();
        for (int c = 0; c < 9; c++) begin
            i_valid = (c < 5);
            i_data  = 8'(c + 1);
            #1;
            chk("t1_ovalid", o_valid, (c >= 3 && c < 8));
            if (c >= 3 && c < 8) chk("t1_odata", o_data, c - 2);
            if (c >= 3 && c <= 5) chk("t1_count", count, 3);
            step();
        end
        i_valid = 1'b0;
        step();

        // stalled consumer fills pipe, then drains in order
        o_ready = 1'b0;
        cur = 8'h10;
        for (int c = 0; c < 5; c++) begin
            i_valid = 1'b1;
            i_data  = cur;
            #1;
            chk("t2_iready", i_ready, (c < 3));
            fire = i_ready;
            step();
            if (fire) cur++;
        end
        #1 chk("t2_count_full", count, 3);
        o_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            i_valid = (cur <= 8'h14);
            i_data  = cur;
            #1;
            chk("t2_ovalid", o_valid, 1);
            chk("t2_odata", o_data, 8'h10 + j);
            fire = i_valid & i_ready;
            step();
            if (fire) cur++;
        end
        i_valid = 1'b0;
        #1 chk("t2_empty", o_valid, 0);
        step();

        // bubbles collapse while consumer stalled
        o_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            i_valid = (c == 0 || c == 3);
            i_data  = (c == 3) ? 8'hA1 : 8'hA0;
            #1;
            chk("t3_iready", i_ready, 1);
            if (c >= 4) chk("t3_count", count, 2);
            step();
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        #1;
        chk("t3_ovalid0", o_valid, 1);
        chk("t3_odata0", o_data, 8'hA0);
        step();
        #1;
        chk("t3_ovalid1", o_valid, 1);
        chk("t3_odata1", o_data, 8'hA1);
        step();
        #1 chk("t3_done", o_valid, 0);
        step();

        // flush with output transfer in the same cycle
        o_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            i_valid = 1'b1;
            i_data  = 8'(8'h20 + c);
            step();
        end
        o_ready = 1'b1;
        flush   = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'h23;
        #1;
        chk("t4_iready_flush", i_ready, 0);
        chk("t4_ovalid", o_valid, 1);
        chk("t4_odata", o_data, 8'h20);
        step();
        flush   = 1'b0;
        i_valid = 1'b0;
        #1;
        chk("t4_ovalid_after", o_valid, 0);
        chk("t4_count_after", count, 0);
        repeat (5) step();

        // reset mid-stream
        o_ready = 1'b1;
        cur = 8'h30;
        for (int c = 0; c < 5; c++) begin
            reset   = (c == 4);
            i_valid = 1'b1;
            i_data  = cur;
            #1;
            if (c == 4) chk("t5_iready_rst", i_ready, 0);
            fire = i_valid & i_ready;
            step();
            if (fire) cur++;
        end
        reset   = 1'b0;
        i_valid = 1'b0;
        #1;
        chk("t5_ovalid", o_valid, 0);
        chk("t5_count", count, 0);
        chk("t5_iready", i_ready, 1);
`ifdef VALID_PIPE_DATA_RESET_EN
        chk("t5_odata", o_data, 0);
`endif
        step();

        // random handshakes
        sent = 0;
        cyc  = 0;
        cur  = 8'h00;
        while (sent < 1000 && cyc < 20000) begin
            o_ready = 1'($urandom_range(0, 1));
            i_valid = 1'($urandom_range(0, 1));
            i_data  = cur;
            #1;
            fire = i_valid & i_ready;
            step();
            if (fire) begin
                cur++;
                sent++;
            end
            cyc++;
        end
        chk("t6_sent", sent, 1000);
        i_valid = 1'b0;
        o_ready = 1'b1;
        for (int w = 0; w < 20 && count != 0; w++) step();
        #1;
        chk("t6_drained_sb", sb_q.size(), 0);
        chk("t6_drained_count", count, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
